// File: rtl/rcv_block_fifo.sv
// Receive FIFO: 8 x 32-bit words in, 128-bit blocks out.
// Enqueue one word per strobe, dequeue four words per block.
module rcv_block_fifo #(
  parameter int DEPTH = 8
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [31:0]  HWDATA,
  input  logic         rcv_enq_word,
  input  logic         deq_block,
  input  logic         clear,
  output logic [127:0] block_out,
  output logic         block_ready,
  output logic         rcv_fifo_full,
  output logic         rcv_fifo_empty,
  output logic [3:0]   word_count,
  output logic         overflow,
  output logic         underflow
);

  logic [31:0] mem [DEPTH];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic        enq_ok;
  logic        deq_ok;
  logic [3:0]  cnt_nxt;

  assign rcv_fifo_full  = (word_count == 4'd8);
  assign rcv_fifo_empty = (word_count == 4'd0);
  assign block_ready    = (word_count >= 4'd4);

  assign enq_ok = rcv_enq_word && !rcv_fifo_full;
  assign deq_ok = deq_block && block_ready;

  always_comb begin
    cnt_nxt = word_count;
    if (enq_ok) cnt_nxt = cnt_nxt + 4'd1;
    if (deq_ok) cnt_nxt = cnt_nxt - 4'd4;
  end

  // Storage is deliberately left unreset; only pointers and count matter.
  always_ff @(posedge HCLK) begin
    if (enq_ok && !clear)
      mem[wr_ptr] <= HWDATA;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      word_count <= 4'd0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= 3'd0;
      rd_ptr     <= 3'd0;
      word_count <= 4'd0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (enq_ok)
        wr_ptr <= wr_ptr + 3'd1;
      if (deq_ok)
        rd_ptr <= rd_ptr + 3'd4;
      if (rcv_enq_word && rcv_fifo_full)
        overflow <= 1'b1;
      if (deq_block && !block_ready)
        underflow <= 1'b1;
      word_count <= cnt_nxt;
    end
  end

  // Oldest word lands in the top lane.
  assign block_out = {mem[rd_ptr],
                      mem[rd_ptr + 3'd1],
                      mem[rd_ptr + 3'd2],
                      mem[rd_ptr + 3'd3]};

endmodule

// File: tb/tb_rcv_block_fifo.sv
// Randomized bench for rcv_block_fifo.
// Reference model is a word queue plus two sticky flags.
module tb_rcv_block_fifo;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [31:0]  HWDATA;
  logic         rcv_enq_word;
  logic         deq_block;
  logic         clear;
  logic [127:0] block_out;
  logic         block_ready;
  logic         rcv_fifo_full;
  logic         rcv_fifo_empty;
  logic [3:0]   word_count;
  logic         overflow;
  logic         underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q[$];
  logic        m_ov;
  logic        m_un;

  rcv_block_fifo #(.DEPTH(8)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HWDATA        (HWDATA),
    .rcv_enq_word  (rcv_enq_word),
    .deq_block     (deq_block),
    .clear         (clear),
    .block_out     (block_out),
    .block_ready   (block_ready),
    .rcv_fifo_full (rcv_fifo_full),
    .rcv_fifo_empty(rcv_fifo_empty),
    .word_count    (word_count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("word_count", 128'(word_count), 128'(n));
    chk("empty", 128'(rcv_fifo_empty), 128'(n == 0));
    chk("full", 128'(rcv_fifo_full), 128'(n == 8));
    chk("ready", 128'(block_ready), 128'(n >= 4));
    chk("overflow", 128'(overflow), 128'(m_ov));
    chk("underflow", 128'(underflow), 128'(m_un));
    if (n >= 4)
      chk("block_out", block_out, {q[0], q[1], q[2], q[3]});
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
  endtask

  task automatic cycle(input logic e, input logic [31:0] d,
                       input logic r, input logic c);
    bit e_ok;
    bit r_ok;
    rcv_enq_word = e;
    HWDATA       = d;
    deq_block    = r;
    clear        = c;
    @(posedge HCLK);
    if (c) begin
      model_reset();
    end else begin
      e_ok = e && (q.size() < 8);
      r_ok = r && (q.size() >= 4);
      if (e && !e_ok) m_ov = 1'b1;
      if (r && !r_ok) m_un = 1'b1;
      if (r_ok) repeat (4) void'(q.pop_front());
      if (e_ok) q.push_back(d);
    end
    #1;
    rcv_enq_word = 1'b0;
    deq_block    = 1'b0;
    clear        = 1'b0;
    check_all();
  endtask

  initial begin
    HRESETn      = 1'b0;
    HWDATA       = '0;
    rcv_enq_word = 1'b0;
    deq_block    = 1'b0;
    clear        = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Four words make one block
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 32'(i), 1'b0, 1'b0);
    chk("blk_1234", block_out,
        128'h00000001_00000002_00000003_00000004);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Nine words: last one dropped
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    chk("ovf_set", 128'(overflow), 128'd1);

    // Pop twice, refill, check wrap
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'hC0 + 32'(i), 1'b0, 1'b0);
    chk("blk_wrap", block_out,
        128'h000000C0_000000C1_000000C2_000000C3);

    // Enqueue and dequeue together at count 4
    cycle(1'b1, 32'hBEEF, 1'b1, 1'b0);
    chk("cnt_one", 128'(word_count), 128'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    chk("beef_top", 128'(block_out[127:96]), 128'h0000BEEF);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Underflow at count 3, then clear beats enqueue
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("unf_set", 128'(underflow), 128'd1);
    cycle(1'b1, 32'h300, 1'b0, 1'b1);
    chk("clr_empty", 128'(rcv_fifo_empty), 128'd1);

    // Asynchronous reset at count 6
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    #2;
    HRESETn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    cycle(1'b1, 32'h11, 1'b0, 1'b0);
    chk("rst_first", 128'(block_out[127:96]), 128'h11);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic e, r, c;
      e = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 25);
      c = ($urandom_range(0, 99) < 3);
      cycle(e, $urandom, r, c);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
